// File: rtl/branch_pkg.sv
// Shared types, counter encodings and helpers for the branch predict unit.
// The optional statistics block is enabled with `define BRANCH_STATS_EN.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_op_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT = 2'b00;
    localparam bht_ctr_t CTR_WNT = 2'b01;
    localparam bht_ctr_t CTR_WT  = 2'b10;
    localparam bht_ctr_t CTR_ST  = 2'b11;

    function automatic logic is_reserved_funct3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // Saturating 2-bit counter step toward the actual outcome.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        if (taken) begin
            if (ctr == CTR_ST) nxt = CTR_ST;
            else               nxt = ctr + 2'b01;
        end else begin
            if (ctr == CTR_SNT) nxt = CTR_SNT;
            else                nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Lookup/resolve bus between the IF/EX stages (master) and the predict unit (slave).
// Statistics outputs are present only with `define BRANCH_STATS_EN.
interface branch_predict_unit_if #(parameter int XLEN = 32);
    logic            lookup_valid;
    logic [XLEN-1:0] lookup_pc;
    logic            predict_valid;
    logic            predict_taken;
    logic            resolve_valid;
    logic            resolve_branch;
    logic [XLEN-1:0] resolve_pc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            resolve_pred;
    logic            take_branch;
    logic            mispredict;
    logic            illegal_branch;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    modport master (
`ifdef BRANCH_STATS_EN
        input  stat_branches, stat_mispredicts,
`endif
        output lookup_valid, lookup_pc, resolve_valid, resolve_branch, resolve_pc,
               funct3, rs1_data, rs2_data, resolve_pred,
        input  predict_valid, predict_taken, take_branch, mispredict, illegal_branch
    );

    modport slave (
`ifdef BRANCH_STATS_EN
        output stat_branches, stat_mispredicts,
`endif
        input  lookup_valid, lookup_pc, resolve_valid, resolve_branch, resolve_pc,
               funct3, rs1_data, rs2_data, resolve_pred,
        output predict_valid, predict_taken, take_branch, mispredict, illegal_branch
    );
endinterface

// File: rtl/branch_compare.sv
// Combinational RV32I branch condition evaluation; reserved funct3 yields cond=0, illegal=1.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic            illegal
);

    // Condition select by funct3; signed compares use the full operand width.
    always_comb begin
        cond    = 1'b0;
        illegal = is_reserved_funct3(funct3);
        case (funct3)
            BEQ:     cond = (rs1 == rs2);
            BNE:     cond = (rs1 != rs2);
            BLT:     cond = ($signed(rs1) <  $signed(rs2));
            BGE:     cond = ($signed(rs1) >= $signed(rs2));
            BLTU:    cond = (rs1 <  rs2);
            BGEU:    cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve + bimodal BHT predictor. Optional counters: `define BRANCH_STATS_EN
// adds saturating stat_branches / stat_mispredicts on the interface.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int       XLEN      = 32,
    parameter int       BHT_DEPTH = 64,
    parameter bht_ctr_t CTR_INIT  = CTR_WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bpu
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bht_ctr_t         bht_r [BHT_DEPTH];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] resolve_idx_s;
    logic             cond_s;
    logic             illegal_s;
    logic             branch_s;
    logic             update_en_s;
    logic             mispredict_s;
    logic             unused_s;

    logic             predict_valid_r;
    logic             predict_taken_r;
    logic             take_branch_r;
    logic             mispredict_r;
    logic             illegal_branch_r;

    assign lookup_idx_s  = bpu.lookup_pc[IDX_W+1:2];
    assign resolve_idx_s = bpu.resolve_pc[IDX_W+1:2];
    assign unused_s      = ^{bpu.lookup_pc, bpu.resolve_pc};

    branch_compare #(.XLEN(XLEN)) u_compare (
        .funct3  (bpu.funct3),
        .rs1     (bpu.rs1_data),
        .rs2     (bpu.rs2_data),
        .cond    (cond_s),
        .illegal (illegal_s)
    );

    assign branch_s     = bpu.resolve_valid & bpu.resolve_branch;
    assign update_en_s  = branch_s & ~illegal_s;
    assign mispredict_s = branch_s & (cond_s ^ bpu.resolve_pred);

    // Prediction and resolve flags; lookup reads the table before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            predict_valid_r  <= 1'b0;
            predict_taken_r  <= 1'b0;
            take_branch_r    <= 1'b0;
            mispredict_r     <= 1'b0;
            illegal_branch_r <= 1'b0;
        end else begin
            predict_valid_r  <= bpu.lookup_valid;
            predict_taken_r  <= bht_r[lookup_idx_s][1] & bpu.lookup_valid;
            take_branch_r    <= branch_s & cond_s;
            mispredict_r     <= mispredict_s;
            illegal_branch_r <= branch_s & illegal_s;
        end
    end

    // Counter table training on legal resolved branches only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= CTR_INIT;
            end
        end else if (update_en_s) begin
            bht_r[resolve_idx_s] <= ctr_next(bht_r[resolve_idx_s], cond_s);
        end
    end

    assign bpu.predict_valid  = predict_valid_r;
    assign bpu.predict_taken  = predict_taken_r;
    assign bpu.take_branch    = take_branch_r;
    assign bpu.mispredict     = mispredict_r;
    assign bpu.illegal_branch = illegal_branch_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    // Saturating event counters; mispredicts include reserved-funct3 branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (update_en_s && (stat_branches_r != 32'hFFFF_FFFF)) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (mispredict_s && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign bpu.stat_branches    = stat_branches_r;
    assign bpu.stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized + directed bench for branch_predict_unit with a queue-based scoreboard.
module tb_branch_predict_unit;

    localparam int DEPTH = 64;

    typedef struct {
        int          edge_n;
        bit          pv;
        bit          pt;
        bit          tb;
        bit          mp;
        bit          il;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int          bht_m [DEPTH];
    logic [31:0] sb_m;
    logic [31:0] sm_m;

    branch_predict_unit_if #(.XLEN(32)) bif ();

    branch_predict_unit dut (
        .clk (clk),
        .rst (rst),
        .bpu (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
        sb_m = 32'd0;
        sm_m = 32'd0;
    endtask

    function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs and queue what the next edge must produce.
    task automatic step(input bit lv, input logic [31:0] lpc, input bit rv, input bit rb,
                        input logic [31:0] rpc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input bit pred);
        exp_t e;
        int   li;
        int   ri;
        bit   c;
        @(posedge clk);
        #1;
        bif.lookup_valid   = lv;
        bif.lookup_pc      = lpc;
        bif.resolve_valid  = rv;
        bif.resolve_branch = rb;
        bif.resolve_pc     = rpc;
        bif.funct3         = f3;
        bif.rs1_data       = a;
        bif.rs2_data       = b;
        bif.resolve_pred   = pred;
        li = int'(lpc[7:2]);
        ri = int'(rpc[7:2]);
        e.edge_n = cyc + 1;
        e.pv = lv;
        e.pt = lv && (bht_m[li] >= 2);
        e.tb = 1'b0;
        e.mp = 1'b0;
        e.il = 1'b0;
        if (rv && rb) begin
            c = ref_cond(f3, a, b);
            e.il = (f3 == 3'd2) || (f3 == 3'd3);
            e.tb = c;
            e.mp = c ^ pred;
            if (!e.il) begin
                if (c) bht_m[ri] = (bht_m[ri] == 3) ? 3 : bht_m[ri] + 1;
                else   bht_m[ri] = (bht_m[ri] == 0) ? 0 : bht_m[ri] - 1;
                if (sb_m != 32'hFFFF_FFFF) sb_m = sb_m + 32'd1;
            end
            if (e.mp && sm_m != 32'hFFFF_FFFF) sm_m = sm_m + 32'd1;
        end
        e.sb = sb_m;
        e.sm = sm_m;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        bif.lookup_valid   = 1'b0;
        bif.lookup_pc      = 32'd0;
        bif.resolve_valid  = 1'b0;
        bif.resolve_branch = 1'b0;
        bif.resolve_pc     = 32'd0;
        bif.funct3         = 3'd0;
        bif.rs1_data       = 32'd0;
        bif.rs2_data       = 32'd0;
        bif.resolve_pred   = 1'b0;
    endtask

    // Monitor: pops expectations whose edge has occurred and compares on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (!rst && q.size() > 0 && q[0].edge_n <= cyc) begin
                e = q.pop_front();
                if (e.edge_n != cyc) begin
                    chk("stale_expectation", 32'(e.edge_n), 32'(cyc));
                end else begin
                    chk("predict_valid",  32'(bif.predict_valid),  32'(e.pv));
                    chk("predict_taken",  32'(bif.predict_taken),  32'(e.pt));
                    chk("take_branch",    32'(bif.take_branch),    32'(e.tb));
                    chk("mispredict",     32'(bif.mispredict),     32'(e.mp));
                    chk("illegal_branch", 32'(bif.illegal_branch), 32'(e.il));
`ifdef BRANCH_STATS_EN
                    chk("stat_branches",    bif.stat_branches,    e.sb);
                    chk("stat_mispredicts", bif.stat_mispredicts, e.sm);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] ops [6];
        logic [31:0] pc_a;
        logic [31:0] pc_b;
        pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h100; pcs[3] = 32'h144;
        ops[0] = 32'h0; ops[1] = 32'h1; ops[2] = 32'hFFFF_FFFF;
        ops[3] = 32'h7FFF_FFFF; ops[4] = 32'h8000_0000; ops[5] = 32'h5;

        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_predict_valid", 32'(bif.predict_valid), 32'd0);
        chk("reset_take_branch",   32'(bif.take_branch),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios.
        step(1, 32'h100, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0);
        step(0, 32'h0, 1, 1, 32'h10, 3'd4, 32'hFFFF_FFFF, 32'h1, 0);
        step(0, 32'h0, 1, 1, 32'h10, 3'd6, 32'hFFFF_FFFF, 32'h1, 0);
        repeat (3) step(0, 32'h0, 1, 1, 32'h40, 3'd0, 32'h5, 32'h5, 0);
        step(1, 32'h40, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0);
        repeat (4) step(1, 32'h40, 1, 1, 32'h40, 3'd0, 32'h1, 32'h2, 1);
        step(1, 32'h40, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0);
        step(1, 32'h80, 1, 1, 32'h80, 3'd0, 32'h7, 32'h7, 0);
        step(1, 32'h80, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0);
        step(0, 32'h0, 1, 1, 32'h80, 3'd2, 32'h1, 32'h1, 1);
        step(1, 32'h80, 1, 0, 32'h80, 3'd0, 32'h3, 32'h3, 1);
        step(0, 32'h0, 0, 1, 32'h80, 3'd0, 32'h3, 32'h3, 1);
        repeat (3) step(0, 32'h0, 1, 1, 32'h40, 3'd0, 32'h9, 32'h9, 0);

        // Asynchronous reset between edges while outputs are live.
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        idle_inputs();
        model_reset();
        #1;
        chk("midreset_predict_valid",  32'(bif.predict_valid),  32'd0);
        chk("midreset_predict_taken",  32'(bif.predict_taken),  32'd0);
        chk("midreset_take_branch",    32'(bif.take_branch),    32'd0);
        chk("midreset_mispredict",     32'(bif.mispredict),     32'd0);
        chk("midreset_illegal_branch", 32'(bif.illegal_branch), 32'd0);
`ifdef BRANCH_STATS_EN
        chk("midreset_stat_branches",    bif.stat_branches,    32'd0);
        chk("midreset_stat_mispredicts", bif.stat_mispredicts, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1, 32'h40, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0);

        // Randomized traffic over a few colliding PCs and boundary operands.
        for (int n = 0; n < 600; n++) begin
            pc_a = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
            pc_b = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) pc_b = pc_a;
            step($urandom_range(0, 1), pc_a, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0, pc_b, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0) ? $urandom : ops[$urandom_range(0, 5)],
                 ($urandom_range(0, 2) == 0) ? $urandom : ops[$urandom_range(0, 5)],
                 $urandom_range(0, 1));
        end

        step(0, 32'h0, 0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #6;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
